// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: decodes one RV32I instruction per handshake into
// ALU op/operands plus side-band control, buffered in a 2-entry skid buffer.
module alu_issue (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_op,
  output logic [31:0] out_lhs,
  output logic [31:0] out_rhs,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [1:0]  out_class,
  output logic        out_illegal
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_EQ = 5'd10,  OP_NEQ = 5'd11;
  localparam logic [4:0] OP_LT = 5'd12,  OP_GE = 5'd13,  OP_LTU = 5'd14, OP_GEU = 5'd15;

  localparam logic [1:0] CLS_ALU = 2'd0, CLS_BRANCH = 2'd1, CLS_MEM = 2'd2, CLS_JUMP = 2'd3;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;

  localparam logic [1:0] ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  cls;
    logic        illegal;
  } entry_t;

  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? OP_SUB : OP_ADD;
      3'b001:  alu_op = OP_SLL;
      3'b010:  alu_op = OP_SLT;
      3'b011:  alu_op = OP_SLTU;
      3'b100:  alu_op = OP_XOR;
      3'b101:  alu_op = alt ? OP_SRA : OP_SRL;
      3'b110:  alu_op = OP_OR;
      default: alu_op = OP_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        is_shift;
  logic        bad;
  entry_t      dec;

  assign opcode   = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign f7       = in_inst[31:25];
  assign imm_i    = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b    = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u    = {in_inst[31:12], 12'b0};
  assign imm_j    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec    = '0;
    bad    = 1'b0;
    dec.op = OP_ADD;
    dec.pc = in_pc;
    dec.rd = in_inst[11:7];
    case (opcode)
      OPC_OP: begin
        // The ALU shifts by the full rhs, so only the low five bits of rs2 may pass.
        dec.lhs = in_rs1;
        dec.rhs = is_shift ? {27'b0, in_rs2[4:0]} : in_rs2;
        dec.op  = alu_op(f3, in_inst[30]);
        dec.wen = 1'b1;
        bad     = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        dec.lhs = in_rs1;
        dec.rhs = is_shift ? {27'b0, in_inst[24:20]} : imm_i;
        dec.imm = imm_i;
        dec.op  = alu_op(f3, (f3 == 3'b101) && in_inst[30]);
        dec.wen = 1'b1;
        bad     = is_shift && !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'b101)));
      end
      OPC_LUI: begin
        dec.rhs = imm_u;
        dec.imm = imm_u;
        dec.wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.lhs = in_pc;
        dec.rhs = imm_u;
        dec.imm = imm_u;
        dec.wen = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.lhs = in_pc;
        dec.rhs = 32'd4;
        dec.imm = (opcode == OPC_JAL) ? imm_j : imm_i;
        dec.cls = CLS_JUMP;
        dec.wen = 1'b1;
        bad     = (opcode == OPC_JALR) && (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.lhs = in_rs1;
        dec.rhs = in_rs2;
        dec.imm = imm_b;
        dec.cls = CLS_BRANCH;
        case (f3)
          3'b000:  dec.op = OP_EQ;
          3'b001:  dec.op = OP_NEQ;
          3'b100:  dec.op = OP_LT;
          3'b101:  dec.op = OP_GE;
          3'b110:  dec.op = OP_LTU;
          3'b111:  dec.op = OP_GEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec.lhs = in_rs1;
        dec.rhs = (opcode == OPC_LOAD) ? imm_i : imm_s;
        dec.imm = dec.rhs;
        dec.cls = CLS_MEM;
        dec.wen = (opcode == OPC_LOAD);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.op      = OP_ADD;
      dec.pc      = in_pc;
      dec.rd      = in_inst[11:7];
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.wen = 1'b0;
  end

  logic [1:0] state_reg, state_next;
  entry_t     head_reg, skid_reg;
  logic       head_load, head_from_skid, skid_load;
  logic       accept, drain;

  assign in_ready  = (state_reg != ST_TWO);
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) begin
          head_load  = 1'b1;
          state_next = ST_ONE;
        end
        ST_ONE: begin
          if (accept && !drain) begin
            skid_load  = 1'b1;
            state_next = ST_TWO;
          end else if (drain && !accept) begin
            state_next = ST_EMPTY;
          end else if (drain && accept) begin
            head_load = 1'b1;
          end
        end
        ST_TWO: if (drain) begin
          head_from_skid = 1'b1;
          state_next     = ST_ONE;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_reg <= ST_EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (head_load)           head_reg <= dec;
      else if (head_from_skid) head_reg <= skid_reg;
      if (skid_load)           skid_reg <= dec;
    end
  end

  assign out_op      = head_reg.op;
  assign out_lhs     = head_reg.lhs;
  assign out_rhs     = head_reg.rhs;
  assign out_imm     = head_reg.imm;
  assign out_pc      = head_reg.pc;
  assign out_rd      = head_reg.rd;
  assign out_wen     = head_reg.wen;
  assign out_class   = head_reg.cls;
  assign out_illegal = head_reg.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed decode table, handshake corner sequences and
// randomized traffic against a queue-based reference model.
module tb_alu_issue;

  localparam logic [4:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5, SRL = 6, SRA = 7;
  localparam logic [4:0] OR = 8, AND = 9, EQ = 10, NEQ = 11, LT = 12, GE = 13, LTU = 14, GEU = 15;

  logic        CLK = 1'b0;
  logic        RST_X, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, in_rs1, in_rs2;
  logic [4:0]  out_op, out_rd;
  logic [31:0] out_lhs, out_rhs, out_imm, out_pc;
  logic        out_wen, out_illegal;
  logic [1:0]  out_class;

  alu_issue dut (
    .CLK(CLK), .RST_X(RST_X), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_lhs(out_lhs), .out_rhs(out_rhs), .out_imm(out_imm),
    .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen),
    .out_class(out_class), .out_illegal(out_illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] lhs, rhs, imm, pc;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  cls;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst, pc, rs1, rs2;
    exp_t        e;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  exp_t q [$];
  int   errors = 0, checks = 0, drained = 0;
  bit   last_acc;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic exp_t mk(logic [4:0] op, logic [31:0] lhs, rhs, imm, pc,
                              logic [4:0] rd, logic wen, logic [1:0] cls, logic ill);
    exp_t e;
    e.op = op; e.lhs = lhs; e.rhs = rhs; e.imm = imm; e.pc = pc;
    e.rd = rd; e.wen = wen; e.cls = cls; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mv(logic [31:0] inst, pc, rs1, rs2, exp_t e);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.e = e;
    return v;
  endfunction

  // Immediate is only meaningful for branch/jump/mem classes and illegal entries.
  function automatic exp_t got_rec();
    exp_t g;
    g = mk(out_op, out_lhs, out_rhs, out_imm, out_pc, out_rd, out_wen, out_class, out_illegal);
    if (!out_illegal && out_class == 2'd0) g.imm = '0;
    return g;
  endfunction

  function automatic logic [143:0] all_outs();
    return {in_ready, out_valid, out_op, out_lhs, out_rhs, out_imm, out_pc,
            out_rd, out_wen, out_class, out_illegal};
  endfunction

  function automatic logic [4:0] f3_op(logic [2:0] f3, logic alt);
    logic [4:0] m [8];
    m = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    if (alt && f3 == 3'd0) return SUB;
    if (alt && f3 == 3'd5) return SRA;
    return m[f3];
  endfunction

  function automatic exp_t ref_decode(logic [31:0] inst, pc, rs1, rs2);
    exp_t e;
    int unsigned f3, f7, opc;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    bit bad, shift;
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    i_imm = {{20{inst[31]}}, inst[31:20]};
    s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u_imm = inst & 32'hFFFFF000;
    j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    shift = (f3 == 1) || (f3 == 5);
    bad = 0;
    e = mk(ADD, 0, 0, 0, pc, inst[11:7], 1, 0, 0);
    case (opc)
      'h33: begin
        e.lhs = rs1; e.rhs = shift ? rs2 % 32 : rs2; e.op = f3_op(f3[2:0], inst[30]);
        bad = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
      end
      'h13: begin
        e.lhs = rs1; e.rhs = shift ? 32'(inst[24:20]) : i_imm;
        e.op = f3_op(f3[2:0], f3 == 5 && inst[30]);
        bad = shift && !(f7 == 0 || (f7 == 'h20 && f3 == 5));
      end
      'h37: e.rhs = u_imm;
      'h17: begin e.lhs = pc; e.rhs = u_imm; end
      'h6F: begin e.lhs = pc; e.rhs = 4; e.imm = j_imm; e.cls = 3; end
      'h67: begin e.lhs = pc; e.rhs = 4; e.imm = i_imm; e.cls = 3; bad = (f3 != 0); end
      'h63: begin
        e.lhs = rs1; e.rhs = rs2; e.imm = b_imm; e.cls = 1; e.wen = 0;
        case (f3)
          0: e.op = EQ;  1: e.op = NEQ; 4: e.op = LT;
          5: e.op = GE;  6: e.op = LTU; 7: e.op = GEU;
          default: bad = 1;
        endcase
      end
      'h03: begin e.lhs = rs1; e.rhs = i_imm; e.imm = i_imm; e.cls = 2; end
      'h23: begin e.lhs = rs1; e.rhs = s_imm; e.imm = s_imm; e.cls = 2; e.wen = 0; end
      default: bad = 1;
    endcase
    if (bad) e = mk(ADD, 0, 0, 0, pc, inst[11:7], 0, 0, 1);
    if (e.rd == 0) e.wen = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    int k;
    logic [6:0] opcs [9];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
    x = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) x[6:0] = opcs[k];
    if ((k == 0 || k == 1) && $urandom_range(0, 3) != 0) x[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    if (k == 5 && $urandom_range(0, 1) == 1) x[14:12] = 3'd0;
    return x;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, pc, rs1, rs2);
    in_valid = v; in_inst = inst; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, rand_inst(), $urandom, $urandom, $urandom);
  endtask

  // One clock: check the DUT against the model, advance the model across the edge.
  task automatic cycle();
    bit acc, drn, kill;
    exp_t d;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) chk("head", got_rec(), q[0]);
    acc  = in_valid && (q.size() < 2);
    drn  = out_ready && (q.size() > 0);
    kill = !RST_X || flush;
    d    = ref_decode(in_inst, in_pc, in_rs1, in_rs2);
    @(posedge CLK);
    if (kill) begin
      q.delete();
    end else begin
      if (drn) begin
        $display("txn pc=%h op=%0d lhs=%h rhs=%h imm=%h rd=%0d wen=%0d cls=%0d ill=%0d",
                 q[0].pc, q[0].op, q[0].lhs, q[0].rhs, q[0].imm, q[0].rd, q[0].wen, q[0].cls, q[0].ill);
        void'(q.pop_front());
        drained++;
      end
      if (acc) q.push_back(d);
    end
    last_acc = acc && !kill;
    #1;
  endtask

  initial begin
    logic [143:0] rst_want;
    logic [31:0]  pcs [3];
    int           start;

    vecs[0]  = mv(32'h40B50533, 32'h1000, 10, 3, mk(SUB, 10, 3, 0, 32'h1000, 10, 1, 0, 0));
    vecs[1]  = mv(32'h003110B3, 32'h1004, 32'h12345678, 32'h21, mk(SLL, 32'h12345678, 1, 0, 32'h1004, 1, 1, 0, 0));
    vecs[2]  = mv(32'h40335293, 32'h1008, 32'h80000000, 32'hFFFFFFFF, mk(SRA, 32'h80000000, 3, 0, 32'h1008, 5, 1, 0, 0));
    vecs[3]  = mv(32'h00208863, 32'h100C, 5, 5, mk(EQ, 5, 5, 16, 32'h100C, 16, 0, 1, 0));
    vecs[4]  = mv(32'hFE419EE3, 32'h1010, 7, 8, mk(NEQ, 7, 8, 32'hFFFFFFFC, 32'h1010, 29, 0, 1, 0));
    vecs[5]  = mv(32'h00202063, 32'h1014, 32'hAA, 32'hBB, mk(ADD, 0, 0, 0, 32'h1014, 0, 0, 0, 1));
    vecs[6]  = mv(32'h008000EF, 32'h100, 32'h55, 32'h66, mk(ADD, 32'h100, 4, 8, 32'h100, 1, 1, 3, 0));
    vecs[7]  = mv(32'h123451B7, 32'h1018, 32'hFFFFFFFF, 1, mk(ADD, 0, 32'h12345000, 0, 32'h1018, 3, 1, 0, 0));
    vecs[8]  = mv(32'hFFFFF217, 32'h2000, 1, 2, mk(ADD, 32'h2000, 32'hFFFFF000, 0, 32'h2000, 4, 1, 0, 0));
    vecs[9]  = mv(32'hFFC32283, 32'h101C, 32'h400, 9, mk(ADD, 32'h400, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h101C, 5, 1, 2, 0));
    vecs[10] = mv(32'h00742A23, 32'h1020, 32'h800, 32'hDEAD, mk(ADD, 32'h800, 20, 20, 32'h1020, 20, 0, 2, 0));
    vecs[11] = mv(32'h00500013, 32'h1024, 9, 0, mk(ADD, 9, 5, 0, 32'h1024, 0, 0, 0, 0));
    vecs[12] = mv(32'h02208533, 32'h1028, 3, 4, mk(ADD, 0, 0, 0, 32'h1028, 10, 0, 0, 1));
    vecs[13] = mv(32'h00009067, 32'h102C, 3, 4, mk(ADD, 0, 0, 0, 32'h102C, 0, 0, 0, 1));
    vecs[14] = mv(32'h0000000F, 32'h1030, 3, 4, mk(ADD, 0, 0, 0, 32'h1030, 0, 0, 0, 1));
    vecs[15] = mv(32'h00C100E7, 32'h40, 32'h1234, 0, mk(ADD, 32'h40, 4, 12, 32'h40, 1, 1, 3, 0));
    vecs[16] = mv(32'h40B55533, 32'h1034, 32'hF0000000, 32'h24, mk(SRA, 32'hF0000000, 4, 0, 32'h1034, 10, 1, 0, 0));
    vecs[17] = mv(32'h40008113, 32'h1038, 7, 0, mk(ADD, 7, 32'h400, 0, 32'h1038, 2, 1, 0, 0));

    RST_X = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    rst_want = {1'b1, 143'b0};
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", all_outs(), rst_want);
    RST_X = 1'b1;

    // Directed decode table, applied back to back.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(1, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      cycle();
      chk($sformatf("vec%0d", i), got_rec(), vecs[i].e);
    end
    drive(0, 0, 0, 0, 0);
    repeat (2) cycle();

    // Backpressure: A and B fill the buffer, C waits upstream.
    pcs = '{32'hA0, 32'hB0, 32'hC0};
    out_ready = 1'b0;
    drive(1, 32'h00100093, pcs[0], 1, 1); cycle();
    drive(1, 32'h00200113, pcs[1], 2, 2); cycle();
    chk("ready_after_B", in_ready, 1'b0);
    drive(1, 32'h00300193, pcs[2], 3, 3);
    repeat (3) cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("order%0d", k), {out_valid, out_pc}, {1'b1, pcs[k]});
      cycle();
      if (last_acc) in_valid = 1'b0;
    end
    cycle();

    // Continuous traffic: 8 in, 8 out, no bubble.
    start = drained;
    for (int k = 0; k < 8; k++) begin
      drive_rand(1);
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    cycle();
    chk("burst_count", drained - start, 8);

    // Flush in state ONE (accept would otherwise happen) and in state TWO.
    for (int depth = 1; depth <= 2; depth++) begin
      out_ready = 1'b0;
      for (int k = 0; k < depth; k++) begin
        drive(1, 32'h00A00513, 32'h3000 + k, 5, 6);
        cycle();
      end
      drive(1, 32'h00B00593, 32'hDEAD0000, 7, 8);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      drive(0, 0, 0, 0, 0);
      chk($sformatf("flush_depth%0d", depth), {out_valid, in_ready}, 2'b01);
      out_ready = 1'b1;
      repeat (2) cycle();
    end

    // Reset with both entries held and an input offered.
    out_ready = 1'b0;
    drive(1, 32'h00C00613, 32'h4000, 1, 2); cycle();
    drive(1, 32'h00D00693, 32'h4004, 3, 4); cycle();
    drive(1, 32'h00E00713, 32'h4008, 5, 6);
    RST_X = 1'b0;
    cycle();
    RST_X = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("midstream_reset", all_outs(), rst_want);
    out_ready = 1'b1;
    repeat (2) cycle();

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 500; n++) begin
      drive_rand($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      RST_X     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    flush = 1'b0; RST_X = 1'b1; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage sitting directly in front of the ALU: accepts one RV32I instruction word plus its PC and register-file operand values through a valid/ready handshake. It decodes the instruction into an ALU op code, lhs/rhs operands and side-band control, and holds the result in a 2-entry skid buffer that feeds the execute stage with full throughput and backpressure. It is the producer of the ALU's `op`/`lhs`/`rhs` inputs, so every op it emits is one of the shared ALU header constants (ADD … GEU).

## Interface
- Parameters: none (XLEN fixed at 32).
- CLK  in  1  clock; all state updates on rising edge.
- RST_X  in  1  synchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction PC.
- in_rs1, in_rs2  in  32  register values for rs1/rs2 fields.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute stage accepts.
- out_op  out  5  ALU op constant.
- out_lhs, out_rhs  out  32  ALU operands.
- out_imm  out  32  decoded immediate (branch/jump/store offset).
- out_pc  out  32  PC of the entry.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable (forced 0 when rd = 0).
- out_class  out  2  0 ALU, 1 BRANCH, 2 MEM, 3 JUMP.
- out_illegal  out  1  undecodable instruction.

## Operation
- Decode is combinational on in_*; the decoded record is written into the buffer on accept (in_valid && in_ready).
- OP (0110011), class ALU, lhs=rs1, rhs=rs2:
  - funct3 map: 000 ADD (SUB if inst[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if inst[30]), 110 OR, 111 AND.
  - Shifts use rhs={27'b0, rs2[4:0]}, because the ALU shifts by the full rhs.
  - funct7 must be 0000000, or 0100000 for ADD/SRL only; anything else is illegal.
- OP-IMM (0010011), class ALU, lhs=rs1:
  - Same funct3 map, no SUB; rhs = sign-extended I-imm.
  - Shifts: rhs = zero-extended inst[24:20]; funct7 0000000 (or 0100000 for SRAI), else illegal.
- LUI: ADD, lhs=0, rhs=U-imm.
- AUIPC: ADD, lhs=pc, rhs=U-imm.
- JAL / JALR: ADD, lhs=pc, rhs=4, class JUMP, imm = J-imm / I-imm.
  - JALR also requires funct3=000; otherwise illegal.
- BRANCH: lhs=rs1, rhs=rs2, wen=0, imm = B-imm, class BRANCH.
  - funct3 map: 000 EQ, 001 NEQ, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - funct3 010/011 is illegal.
- LOAD / STORE: ADD, lhs=rs1, rhs=imm = I-imm / S-imm, class MEM.
  - wen=1 for LOAD only.
- Any other opcode, or any illegal case above, emits: op=ADD, lhs=rhs=imm=0, wen=0, class=0, illegal=1, pc/rd passed through.
- Buffer state machine, updated per cycle:
  - EMPTY: accept → ONE.
  - ONE: accept without drain → TWO; drain without accept → EMPTY; both → ONE, with the head replaced by the new entry.
  - TWO: drain → ONE, the skid entry moves to the head. No accept is possible.
- Strict FIFO order is kept; no entry is lost or duplicated.

## Timing
- Latency: an entry accepted at edge N is presented with out_valid=1 in cycle N+1.
- Throughput: one per cycle while out_ready=1.
- in_ready is a registered output = (state != TWO); it does not depend combinationally on out_ready.
- While out_valid && !out_ready, all out_* are held stable.
- out_* are driven from registers only, with no combinational path from in_*.
- flush=1 at an edge forces EMPTY; any accept in that cycle is discarded.
  - Next cycle: out_valid=0, in_ready=1.
  - flush takes priority over simultaneous accept and drain.
- RST_X=0 at an edge behaves as flush and also clears all data registers.
  - Reset values: out_valid=0, in_ready=1, and every other output 0.
  - Reset mid-stream drops both entries.
- The out_* data of an empty buffer is don't-care except immediately after reset, when it is 0.

## Test plan
- R-type SUB/ADD: in_inst=0x40B50533, rs1=10, rs2=3 → next cycle out_op=SUB, lhs=10, rhs=3, rd=10, wen=1, class=0, illegal=0.
- Shift masking: SLL with rs2=0x00000021 → rhs=1.
  - in_inst=0x40335293 (SRAI x5,x6,3) → op=SRA, rhs=3, rd=5.
- Branch and illegal: BEQ → op=EQ, wen=0, class=1, correct B-imm.
  - Branch with funct3=010 → illegal=1, op=ADD, lhs=rhs=0, wen=0.
  - JAL at pc=0x100 → lhs=0x100, rhs=4, class=3.
- Backpressure: out_ready=0, push A, B, C back-to-back.
  - A and B accepted; in_ready=0 in the cycle after B; C is held upstream.
  - Then raise out_ready: A, B, C emerge in order, one per cycle, and out_* stay stable while stalled.
- Simultaneous accept/drain in state ONE with out_ready=1 and continuous input for 8 cycles → 8 entries out, in order, no bubble after the first.
- Flush and reset: with TWO held, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed input never appears.
  - Repeat with RST_X=0 → all outputs 0.
